// File: rtl/timer_multi.sv
// Multi-channel down-counting timer: one shared prescaler tick drives CHANNELS
// independent one-shot/periodic counters, each with a sticky flag and an expiry pulse.
module timer_multi #(
  parameter int BITS          = 32,
  parameter int CHANNELS      = 4,
  parameter int PRESCALE_BITS = 8
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic [PRESCALE_BITS-1:0]   prescale,
  input  logic [CHANNELS*BITS-1:0]   load,
  input  logic [CHANNELS-1:0]        start,
  input  logic [CHANNELS-1:0]        stop,
  input  logic [CHANNELS-1:0]        periodic,
  input  logic [CHANNELS-1:0]        flag_clear,
  output logic [CHANNELS*BITS-1:0]   count,
  output logic [CHANNELS-1:0]        running,
  output logic [CHANNELS-1:0]        flag,
  output logic [CHANNELS-1:0]        expired,
  output logic                       irq
);

  localparam logic [PRESCALE_BITS-1:0] PRE_ONE = 1;
  localparam logic [BITS-1:0]          CNT_ONE = 1;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  logic [PRESCALE_BITS-1:0] pre_cnt_reg;
  logic                     tick;

  // ">=" rather than "==" so that lowering prescale below pre_cnt ticks at once.
  assign tick = (pre_cnt_reg >= prescale);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pre_cnt_reg <= '0;
    end else if (tick) begin
      pre_cnt_reg <= '0;
    end else begin
      pre_cnt_reg <= pre_cnt_reg + PRE_ONE;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
      state_t          state_reg;
      logic [BITS-1:0] count_reg;
      logic            flag_reg;
      logic            expired_reg;

      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          state_reg   <= IDLE;
          count_reg   <= '0;
          flag_reg    <= 1'b0;
          expired_reg <= 1'b0;
        end else begin
          expired_reg <= 1'b0;
          if (flag_clear[gi]) begin
            flag_reg <= 1'b0;
          end
          // Later assignments win, so an expiry set overrides a same-cycle clear.
          if (stop[gi]) begin
            state_reg <= IDLE;
          end else if (start[gi]) begin
            state_reg <= RUN;
            count_reg <= load[gi*BITS +: BITS];
            flag_reg  <= 1'b0;
          end else if (tick && state_reg == RUN) begin
            if (count_reg == '0) begin
              expired_reg <= 1'b1;
              flag_reg    <= 1'b1;
              if (periodic[gi]) begin
                count_reg <= load[gi*BITS +: BITS];
              end else begin
                state_reg <= IDLE;
              end
            end else begin
              count_reg <= count_reg - CNT_ONE;
            end
          end
        end
      end

      assign count[gi*BITS +: BITS] = count_reg;
      assign running[gi]            = (state_reg == RUN);
      assign flag[gi]               = flag_reg;
      assign expired[gi]            = expired_reg;
    end
  endgenerate

  assign irq = |flag;

endmodule

// File: tb/tb_timer_multi.sv
// Bench for timer_multi: a table of single-cycle vectors at prescale=0, followed by
// hand-written periodic/prescaler and asynchronous-reset sequences.
module tb_timer_multi;

  localparam int BITS = 32;
  localparam int CH   = 4;
  localparam int PB   = 8;

  logic                 clock;
  logic                 reset_n;
  logic [PB-1:0]        prescale;
  logic [CH*BITS-1:0]   load;
  logic [CH-1:0]        start, stop, periodic, flag_clear;
  logic [CH*BITS-1:0]   count;
  logic [CH-1:0]        running, flag, expired;
  logic                 irq;

  int n_cmp  = 0;
  int n_fail = 0;

  timer_multi #(.BITS(BITS), .CHANNELS(CH), .PRESCALE_BITS(PB)) dut (
    .clock(clock), .reset_n(reset_n), .prescale(prescale), .load(load),
    .start(start), .stop(stop), .periodic(periodic), .flag_clear(flag_clear),
    .count(count), .running(running), .flag(flag), .expired(expired), .irq(irq)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [3:0]      st, sp, per, fc;
    logic [3:0][7:0] ld;
    logic [3:0][7:0] cnt;
    logic [3:0]      run, flg, exp;
  } vec_t;

  vec_t vec_q[$];

  task automatic add(input logic [3:0] st, input logic [3:0] sp, input logic [3:0] per,
                     input logic [3:0] fc, input logic [31:0] ld, input logic [31:0] cnt,
                     input logic [3:0] run, input logic [3:0] flg, input logic [3:0] exp);
    vec_t v;
    v.st = st; v.sp = sp; v.per = per; v.fc = fc;
    v.ld = ld; v.cnt = cnt; v.run = run; v.flg = flg; v.exp = exp;
    vec_q.push_back(v);
  endtask

  task automatic check(input string name, input logic [CH*BITS-1:0] act,
                       input logic [CH*BITS-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  function automatic logic [CH*BITS-1:0] widen(input logic [3:0][7:0] b);
    logic [CH*BITS-1:0] r;
    r = '0;
    for (int i = 0; i < CH; i++) r[i*BITS +: BITS] = {24'd0, b[i]};
    return r;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, ".count"},   count, '0);
    check({tag, ".running"}, {124'd0, running}, '0);
    check({tag, ".flag"},    {124'd0, flag}, '0);
    check({tag, ".expired"}, {124'd0, expired}, '0);
    check({tag, ".irq"},     {127'd0, irq}, '0);
  endtask

  initial begin
    reset_n = 1'b0; prescale = '0; load = '0;
    start = '0; stop = '0; periodic = '0; flag_clear = '0;

    // Vectors: inputs applied for one edge, outputs expected just after that edge.
    // Test 1: ch0 one-shot load 3
    add(4'b0001, 0, 0, 0, 32'h00000003, 32'h00000003, 4'b0001, 4'b0000, 4'b0000);
    add(0, 0, 0, 0,       32'h00000003, 32'h00000002, 4'b0001, 4'b0000, 4'b0000);
    add(0, 0, 0, 0,       32'h00000003, 32'h00000001, 4'b0001, 4'b0000, 4'b0000);
    add(0, 0, 0, 0,       32'h00000003, 32'h00000000, 4'b0001, 4'b0000, 4'b0000);
    add(0, 0, 0, 0,       32'h00000003, 32'h00000000, 4'b0000, 4'b0001, 4'b0001);
    add(0, 0, 0, 0,       32'h00000003, 32'h00000000, 4'b0000, 4'b0001, 4'b0000);
    // Test 4: load 0 expires on first tick; set beats a coincident clear
    add(4'b0001, 0, 0, 0, 32'h00000000, 32'h00000000, 4'b0001, 4'b0000, 4'b0000);
    add(0, 0, 0, 4'b0001, 32'h00000000, 32'h00000000, 4'b0000, 4'b0001, 4'b0001);
    add(0, 0, 0, 4'b0001, 32'h00000000, 32'h00000000, 4'b0000, 4'b0000, 4'b0000);
    // Test 3: ch2 stop+start at count 5 holds, later start reloads
    add(4'b0100, 0, 0, 0, 32'h00070000, 32'h00070000, 4'b0100, 4'b0000, 4'b0000);
    add(0, 0, 0, 0,       32'h00070000, 32'h00060000, 4'b0100, 4'b0000, 4'b0000);
    add(0, 0, 0, 0,       32'h00070000, 32'h00050000, 4'b0100, 4'b0000, 4'b0000);
    add(4'b0100, 4'b0100, 0, 0, 32'h00070000, 32'h00050000, 4'b0000, 4'b0000, 4'b0000);
    add(0, 0, 0, 0,       32'h00070000, 32'h00050000, 4'b0000, 4'b0000, 4'b0000);
    add(0, 0, 0, 0,       32'h00070000, 32'h00050000, 4'b0000, 4'b0000, 4'b0000);
    add(4'b0100, 0, 0, 0, 32'h00020000, 32'h00020000, 4'b0100, 4'b0000, 4'b0000);
    add(0, 0, 0, 0,       32'h00020000, 32'h00010000, 4'b0100, 4'b0000, 4'b0000);
    add(0, 0, 0, 0,       32'h00020000, 32'h00000000, 4'b0100, 4'b0000, 4'b0000);
    add(0, 0, 0, 0,       32'h00020000, 32'h00000000, 4'b0000, 4'b0100, 4'b0100);
    add(0, 0, 0, 4'b0100, 32'h00020000, 32'h00000000, 4'b0000, 4'b0000, 4'b0000);
    // Test 5: all channels load 2 started together; restart of ch1 clears only its flag
    add(4'b1111, 0, 0, 0, 32'h02020202, 32'h02020202, 4'b1111, 4'b0000, 4'b0000);
    add(0, 0, 0, 0,       32'h02020202, 32'h01010101, 4'b1111, 4'b0000, 4'b0000);
    add(0, 0, 0, 0,       32'h02020202, 32'h00000000, 4'b1111, 4'b0000, 4'b0000);
    add(0, 0, 0, 0,       32'h02020202, 32'h00000000, 4'b0000, 4'b1111, 4'b1111);
    add(4'b0010, 0, 0, 0, 32'h02020502, 32'h00000500, 4'b0010, 4'b1101, 4'b0000);
    // ch3 periodic load 1, mode switched to one-shot mid-run
    add(4'b1000, 0, 4'b1000, 0, 32'h01020502, 32'h01000400, 4'b1010, 4'b0101, 4'b0000);
    add(0, 0, 4'b1000, 0, 32'h01020502, 32'h00000300, 4'b1010, 4'b0101, 4'b0000);
    add(0, 0, 4'b1000, 0, 32'h01020502, 32'h01000200, 4'b1010, 4'b1101, 4'b1000);
    add(0, 0, 0, 0,       32'h01020502, 32'h00000100, 4'b1010, 4'b1101, 4'b0000);
    add(0, 0, 0, 0,       32'h01020502, 32'h00000000, 4'b0010, 4'b1101, 4'b1000);
    add(0, 0, 0, 0,       32'h01020502, 32'h00000000, 4'b0000, 4'b1111, 4'b0010);
    add(0, 0, 0, 0,       32'h01020502, 32'h00000000, 4'b0000, 4'b1111, 4'b0000);

    repeat (3) @(posedge clock);
    #1;
    check_all_zero("reset");
    @(negedge clock);
    reset_n = 1'b1;

    for (int k = 0; k < vec_q.size(); k++) begin
      start = vec_q[k].st; stop = vec_q[k].sp; periodic = vec_q[k].per;
      flag_clear = vec_q[k].fc; load = widen(vec_q[k].ld);
      @(posedge clock);
      #1;
      check($sformatf("v%0d.count", k),   count, widen(vec_q[k].cnt));
      check($sformatf("v%0d.running", k), {124'd0, running}, {124'd0, vec_q[k].run});
      check($sformatf("v%0d.flag", k),    {124'd0, flag},    {124'd0, vec_q[k].flg});
      check($sformatf("v%0d.expired", k), {124'd0, expired}, {124'd0, vec_q[k].exp});
      check($sformatf("v%0d.irq", k),     {127'd0, irq},     {127'd0, |vec_q[k].flg});
      $display("vec %0d: start=%b stop=%b run=%b flag=%b exp=%b irq=%b",
               k, start, stop, running, flag, expired, irq);
      @(negedge clock);
    end
    start = '0; stop = '0; periodic = '0; flag_clear = '0; load = '0;

    // Test 2: prescale=2, ch1 periodic load 1. Reset between edges aligns pre_cnt to 0,
    // so ticks land on edges 3,6,9,... and expiries on every 6th edge.
    @(negedge clock);
    #1 reset_n = 1'b0;
    prescale = 8'd2;
    #1 reset_n = 1'b1;
    start = 4'b0010; periodic = 4'b0010; load = widen(32'h00000100);
    for (int k = 1; k <= 38; k++) begin
      logic exp_flag;
      @(posedge clock);
      #1;
      exp_flag = (k >= 6 && k < 20) || (k >= 24);
      check($sformatf("p%0d.expired1", k), {127'd0, expired[1]}, {127'd0, (k % 6 == 0)});
      check($sformatf("p%0d.running1", k), {127'd0, running[1]}, 128'd1);
      check($sformatf("p%0d.flag1", k),    {127'd0, flag[1]},    {127'd0, exp_flag});
      $display("per edge %0d: count1=%0d exp1=%b flag1=%b", k,
               count[BITS +: BITS], expired[1], flag[1]);
      start = '0;
      flag_clear = (k + 1 == 20) ? 4'b0010 : 4'b0000;
    end

    // Test 6: asynchronous reset mid-run, observed before any clock edge.
    @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    $display("async reset: count=%h run=%b flag=%b irq=%b", count, running, flag, irq);
    @(negedge clock);
    reset_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clock);
      #1;
      check($sformatf("post_rst%0d.expired", k), {124'd0, expired}, '0);
      check($sformatf("post_rst%0d.running", k), {124'd0, running}, '0);
      $display("post reset %0d: run=%b exp=%b", k, running, expired);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
